// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed seven-segment scanner for up to DIGITS digits.
// The value and dp inputs are double-buffered through load so a frame never
// shows a mix of old and new data. Leading-zero blanking is selectable live.
// Build option: define SEG_HEX_EN to show A-F glyphs for nibbles 10-15;
// without it those nibbles show blank segments.
module seg_scan_driver #(
  parameter int DIGITS = 4,
  parameter int SCAN_W = 6,
  parameter int CAT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  lz_blank,
  output logic [CAT_W-1:0]      LED_CAT_out,
  output logic [7:0]            LED_NUM,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SCAN_W-1:0] CNT_MAX = '1;

  logic [SCAN_W-1:0]   r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_val_q;
  logic [DIGITS-1:0]   r_dp_q;
  logic [DIGITS-1:0]   r_cat;
  logic [7:0]          r_num;
  logic                r_frame_done;

  logic [3:0]          w_nib [DIGITS];
  logic [DIGITS-1:0]   w_blank;
  logic [IDX_W-1:0]    w_idx_next;
  logic                w_any_en;
  logic [6:0]          w_glyph;
  logic [7:0]          w_num_next;
  logic [DIGITS-1:0]   w_cat_next;
  logic                w_slot_start;
  logic                w_guard;

  // Segment pattern {g,f,e,d,c,b,a} for one nibble.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h27;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h67;
`ifdef SEG_HEX_EN
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
`endif
      default: glyph = 7'h00;
    endcase
  endfunction

  assign w_slot_start = (r_cnt == '0);
  assign w_guard      = (r_cnt == CNT_MAX);

  // Split the shadow value into per-digit nibbles.
  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      w_nib[k] = r_val_q[4*k +: 4];
    end
  end

  // A digit is a leading zero when it and every higher nibble are zero; digit 0 always shows.
  always_comb begin
    logic w_hi_zero;
    w_hi_zero = 1'b1;
    w_blank   = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_hi_zero  = w_hi_zero & (w_nib[k] == 4'd0);
      w_blank[k] = lz_blank & w_hi_zero & (k != 0);
    end
  end

  // Priority search for the next enabled digit after r_idx, wrapping; the
  // reverse loop lets the nearest candidate overwrite farther ones.
  always_comb begin
    logic [IDX_W:0] w_cand;
    w_idx_next = r_idx;
    w_any_en   = 1'b0;
    w_cand     = '0;
    for (int i = DIGITS; i >= 1; i--) begin
      w_cand = {1'b0, r_idx} + (IDX_W+1)'(i);
      if (w_cand >= (IDX_W+1)'(DIGITS)) begin
        w_cand = w_cand - (IDX_W+1)'(DIGITS);
      end
      if (digit_en[w_cand[IDX_W-1:0]]) begin
        w_idx_next = w_cand[IDX_W-1:0];
        w_any_en   = 1'b1;
      end
    end
  end

  // Display data for the digit about to be selected.
  always_comb begin
    w_glyph    = w_blank[w_idx_next] ? 7'h00 : glyph(w_nib[w_idx_next]);
    w_num_next = {r_dp_q[w_idx_next], w_glyph};
    w_cat_next = ~(DIGITS'(1) << w_idx_next);
  end

  // Free-running slot counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + SCAN_W'(1);
    end
  end

  // Shadow registers: the display only ever reads these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val_q <= '0;
      r_dp_q  <= '0;
    end else if (load) begin
      r_val_q <= value;
      r_dp_q  <= dp;
    end
  end

  // Slot sequencing: select and light a digit at slot start, blank segments on the guard cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= IDX_W'(DIGITS - 1);
      r_cat        <= '1;
      r_num        <= 8'h00;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_slot_start) begin
        if (w_any_en) begin
          r_idx        <= w_idx_next;
          r_cat        <= w_cat_next;
          r_num        <= w_num_next;
          r_frame_done <= (w_idx_next <= r_idx);
        end else begin
          r_cat <= '1;
          r_num <= 8'h00;
        end
      end else if (w_guard) begin
        r_num <= 8'h00;
      end
    end
  end

  // Unused select lines above DIGITS stay inactive (high).
  always_comb begin
    LED_CAT_out             = '1;
    LED_CAT_out[DIGITS-1:0] = r_cat;
  end

  assign LED_NUM    = r_num;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (DIGITS=4, SCAN_W=2): a table of display vectors,
// hand sequences for frame timing, shadow loading and reset, and a random
// phase compared cycle by cycle against a behavioural model.
module tb_seg_scan_driver;
  localparam int DIGITS = 4;
  localparam int SCAN_W = 2;
  localparam int CAT_W  = 8;
  localparam int SLOT   = 1 << SCAN_W;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        load     = 1'b0;
  logic [15:0] value    = 16'h0000;
  logic [3:0]  dp       = 4'h0;
  logic [3:0]  digit_en = 4'hF;
  logic        lz_blank = 1'b0;
  logic [7:0]  LED_CAT_out;
  logic [7:0]  LED_NUM;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.DIGITS(DIGITS), .SCAN_W(SCAN_W), .CAT_W(CAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp(dp),
    .digit_en(digit_en), .lz_blank(lz_blank),
    .LED_CAT_out(LED_CAT_out), .LED_NUM(LED_NUM), .frame_done(frame_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  logic [6:0] glyph_tab [16];

  function automatic int next_en(input int cur, input logic [3:0] en);
    for (int off = 1; off <= 4; off++) begin
      if (en[2'((cur + off) % 4)]) return (cur + off) % 4;
    end
    return -1;
  endfunction

  function automatic logic [7:0] seg_of(input int k, input logic [15:0] v,
                                        input logic [3:0] d, input logic lz);
    logic [15:0] upper;
    logic [6:0]  s;
    upper = v >> (4 * k);
    s = glyph_tab[upper[3:0]];
    if (lz && k != 0 && upper == 16'd0) s = 7'd0;
    return {d[2'(k)], s};
  endfunction

  int         m_cnt = 0;
  int         m_idx = DIGITS - 1;
  logic [15:0] m_val = 16'h0;
  logic [3:0]  m_dp  = 4'h0;
  logic [7:0]  m_cat = 8'hFF;
  logic [7:0]  m_num = 8'h00;
  logic        m_fd  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_idx <= DIGITS - 1; m_val <= 16'h0; m_dp <= 4'h0;
      m_cat <= 8'hFF; m_num <= 8'h00; m_fd <= 1'b0;
    end else begin
      m_cnt <= (m_cnt + 1) % SLOT;
      if (load) begin
        m_val <= value;
        m_dp  <= dp;
      end
      m_fd <= 1'b0;
      if (m_cnt == 0) begin
        if (next_en(m_idx, digit_en) < 0) begin
          m_cat <= 8'hFF;
          m_num <= 8'h00;
        end else begin
          m_idx <= next_en(m_idx, digit_en);
          m_cat <= ~(8'd1 << next_en(m_idx, digit_en));
          m_num <= seg_of(next_en(m_idx, digit_en), m_val, m_dp, lz_blank);
          m_fd  <= (next_en(m_idx, digit_en) <= m_idx);
        end
      end else if (m_cnt == SLOT - 1) begin
        m_num <= 8'h00;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_cat", LED_CAT_out, m_cat);
    chk("model_num", LED_NUM, m_num);
    chk("model_fd", frame_done, m_fd);
  end

  // ---------------- directed helpers ----------------
  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dpv;
    logic        lz;
    logic [31:0] exp;   // {d3,d2,d1,d0}
  } vec_t;

  localparam int NV = 8;
  vec_t tbl [NV];

  task automatic wait_sel(input int k, output bit ok);
    logic [7:0] want, prev;
    want = ~(8'd1 << k);
    prev = LED_CAT_out;
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      if (LED_CAT_out == want && prev != want) ok = 1'b1;
      prev = LED_CAT_out;
    end
    chk($sformatf("sel%0d_found", k), {31'd0, ok}, 32'd1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic meas_period(input int exp, input string nm);
    int n;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      seen = frame_done;
    end
    chk({nm, "_first"}, {31'd0, seen}, 32'd1);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      n++;
      seen = frame_done;
    end
    chk(nm, n, exp);
  endtask

  initial begin
    bit ok;
    int n;
    glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
`ifdef SEG_HEX_EN
                  7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`else
                  7'h7F, 7'h67, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
`endif
    tbl[0] = '{16'h1234, 4'b0000, 1'b0, 32'h065B4F66};
    tbl[1] = '{16'h0040, 4'b1000, 1'b1, 32'h8000663F};
    tbl[2] = '{16'h0000, 4'b0000, 1'b1, 32'h0000003F};
    tbl[3] = '{16'h0000, 4'b0000, 1'b0, 32'h3F3F3F3F};
    tbl[4] = '{16'h5678, 4'b0101, 1'b0, 32'h6DFD27FF};
    tbl[5] = '{16'h0900, 4'b0000, 1'b1, 32'h00673F3F};
`ifdef SEG_HEX_EN
    tbl[6] = '{16'hABCD, 4'b0000, 1'b0, 32'h777C395E};
    tbl[7] = '{16'h00A0, 4'b0000, 1'b1, 32'h0000773F};
`else
    tbl[6] = '{16'hABCD, 4'b0000, 1'b0, 32'h00000000};
    tbl[7] = '{16'h00A0, 4'b0000, 1'b1, 32'h0000003F};
`endif

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_cat", LED_CAT_out, 8'hFF);
    chk("rst_num", LED_NUM, 8'h00);
    chk("rst_fd", frame_done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_cat", LED_CAT_out, 8'hFE);
    chk("first_num", LED_NUM, 8'h3F);
    chk("first_fd", frame_done, 1'b1);

    // display vectors
    for (int t = 0; t < NV; t++) begin
      lz_blank = tbl[t].lz;
      digit_en = 4'hF;
      do_load(tbl[t].val, tbl[t].dpv);
      repeat (40) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        wait_sel(k, ok);
        chk($sformatf("vec%0d_d%0d", t, k), LED_NUM, tbl[t].exp[8*k +: 8]);
      end
    end

    // full scan: frame period and one guard cycle per slot
    lz_blank = 1'b0;
    do_load(16'h1234, 4'h0);
    meas_period(16, "fd_full");
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (LED_NUM == 8'h00) n++;
    end
    chk("guard_cycles", n, 4);

    // load in the middle of digit 1's slot
    wait_sel(1, ok);
    value = 16'h9999; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("shadow_hold_a", LED_NUM, 8'h4F);
    @(negedge clk);
    chk("shadow_hold_b", LED_NUM, 8'h4F);
    @(negedge clk);
    chk("shadow_guard", LED_NUM, 8'h00);
    chk("shadow_cat", LED_CAT_out, 8'hFD);
    wait_sel(2, ok);
    chk("shadow_new_d2", LED_NUM, 8'h67);

    // sparse and single-digit scans
    digit_en = 4'b0101;
    meas_period(8, "fd_sparse");
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (LED_CAT_out == 8'hFD || LED_CAT_out == 8'hF7) n++;
    end
    chk("sparse_skip", n, 0);
    digit_en = 4'b0100;
    meas_period(4, "fd_single");

    // nothing enabled
    digit_en = 4'b0000;
    repeat (8) @(negedge clk);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frame_done) n++;
    end
    chk("off_fd", n, 0);
    chk("off_cat", LED_CAT_out, 8'hFF);
    chk("off_num", LED_NUM, 8'h00);

    // asynchronous reset mid-frame clears outputs and shadow contents
    digit_en = 4'hF;
    do_load(16'h8888, 4'hF);
    repeat (21) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_cat", LED_CAT_out, 8'hFF);
    chk("mid_rst_num", LED_NUM, 8'h00);
    chk("mid_rst_fd", frame_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sel(0, ok);
    chk("mid_rst_lost", LED_NUM, 8'h3F);

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 399) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      load = ($urandom_range(0, 7) == 0);
      value = ($urandom_range(0, 1) == 0) ? 16'($urandom) : (16'($urandom) & 16'h00F0);
      dp = 4'($urandom);
      if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 15) == 0) lz_blank = 1'($urandom);
    end
    load = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
